// File: rtl/fetch_decode_unit_if.sv
// rtl/fetch_decode_unit_if.sv - instruction store and execution-unit bus between fetch/decode and the EU
interface fetch_decode_unit_if #(
    parameter int IW = 21
);
    logic [4:0]    instr_addr;
    logic [IW-1:0] instr_data;
    logic [3:0]    flag_in;
    logic [3:0]    opcode;
    logic [4:0]    addr1;
    logic [4:0]    addr2;
    logic [4:0]    addr3;
    logic          eu_en;
    logic          mem_we;

    modport master (
        output instr_addr,
        output opcode,
        output addr1,
        output addr2,
        output addr3,
        output eu_en,
        output mem_we,
        input  instr_data,
        input  flag_in
    );

    modport slave (
        input  instr_addr,
        input  opcode,
        input  addr1,
        input  addr2,
        input  addr3,
        input  eu_en,
        input  mem_we,
        output instr_data,
        output flag_in
    );
endinterface

// File: rtl/fetch_decode_unit.sv
// rtl/fetch_decode_unit.sv - fetch/decode/sequencer for the 8-bit execution unit
module fetch_decode_unit #(
    parameter int IW     = 21,
    parameter int ZF_BIT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    fetch_decode_unit_if.master  bus,
    output logic [4:0]           pc,
    output logic [3:0]           flags_q,
    output logic                 busy,
    output logic                 halted,
    output logic [7:0]           retired
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALTED    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        C_ALU  = 2'b00,
        C_JMP  = 2'b01,
        C_JZ   = 2'b10,
        C_HALT = 2'b11
    } iclass_t;

    state_t        state;
    logic [IW-1:0] ir;
    logic [4:0]    instr_addr_q;
    logic [3:0]    opcode_q;
    logic [4:0]    addr1_q;
    logic [4:0]    addr2_q;
    logic [4:0]    addr3_q;
    logic          eu_en_q;
    logic          mem_we_q;

    logic [1:0]    ir_class;
    logic [3:0]    ir_opcode;
    logic [4:0]    ir_addr1;
    logic [4:0]    ir_addr2;
    logic [4:0]    ir_addr3;
    logic [4:0]    pc_inc;

    assign ir_class  = ir[IW-1 -: 2];
    assign ir_opcode = ir[IW-3 -: 4];
    assign ir_addr1  = ir[14:10];
    assign ir_addr2  = ir[9:5];
    assign ir_addr3  = ir[4:0];
    assign pc_inc    = pc + 5'd1;

    assign bus.instr_addr = instr_addr_q;
    assign bus.opcode     = opcode_q;
    assign bus.addr1      = addr1_q;
    assign bus.addr2      = addr2_q;
    assign bus.addr3      = addr3_q;
    assign bus.eu_en      = eu_en_q;
    assign bus.mem_we     = mem_we_q;

    // instr_addr is written alongside pc everywhere so the store sees it in FETCH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            ir           <= '0;
            pc           <= 5'd0;
            instr_addr_q <= 5'd0;
            opcode_q     <= 4'd0;
            addr1_q      <= 5'd0;
            addr2_q      <= 5'd0;
            addr3_q      <= 5'd0;
            flags_q      <= 4'd0;
            retired      <= 8'd0;
            eu_en_q      <= 1'b0;
            mem_we_q     <= 1'b0;
            busy         <= 1'b0;
            halted       <= 1'b0;
        end else begin
            eu_en_q  <= 1'b0;
            mem_we_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_FETCH;
                        busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    ir    <= bus.instr_data;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    opcode_q <= ir_opcode;
                    addr1_q  <= ir_addr1;
                    addr2_q  <= ir_addr2;
                    addr3_q  <= ir_addr3;
                    case (ir_class)
                        C_ALU: begin
                            state   <= S_EXECUTE;
                            eu_en_q <= 1'b1;
                        end
                        C_JMP: begin
                            pc           <= ir_addr3;
                            instr_addr_q <= ir_addr3;
                            state        <= S_FETCH;
                        end
                        C_JZ: begin
                            if (flags_q[ZF_BIT]) begin
                                pc           <= ir_addr3;
                                instr_addr_q <= ir_addr3;
                            end else begin
                                pc           <= pc_inc;
                                instr_addr_q <= pc_inc;
                            end
                            state <= S_FETCH;
                        end
                        default: begin
                            state  <= S_HALTED;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end
                    endcase
                end
                S_EXECUTE: begin
                    state    <= S_WRITEBACK;
                    mem_we_q <= 1'b1;
                end
                S_WRITEBACK: begin
                    flags_q      <= bus.flag_in;
                    pc           <= pc_inc;
                    instr_addr_q <= pc_inc;
                    if (retired != 8'hFF)
                        retired <= retired + 8'd1;
                    state <= S_FETCH;
                end
                S_HALTED: begin
                    if (start) begin
                        pc           <= 5'd0;
                        instr_addr_q <= 5'd0;
                        retired      <= 8'd0;
                        state        <= S_FETCH;
                        busy         <= 1'b1;
                        halted       <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule
